serial_adder: RTL and testbench

Bit-serial ripple adder that takes two WIDTH-bit operands plus carry-in and produces their sum LSB-first over WIDTH clock cycles, using one full-adder cell and a carry flop. It is the additive counterpart to the 4-bit subtractor: it reconstructs a minuend from a difference and subtrahend (a = diff + b) in the adder/subtractor datapath. It uses a start/busy/done handshake so a controller can sequence operations.

---
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit operands
// LSB-first over WIDTH cycles, sequenced by a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift_a;
    logic [WIDTH-1:0] r_shift_b;
    logic [WIDTH-1:0] r_shift_s;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;

    logic             w_s;
    logic             w_carry;
    logic             w_accept;

    // The single full-adder cell works on the current LSBs and the stored carry.
    assign w_s      = r_shift_a[0] ^ r_shift_b[0] ^ r_carry;
    assign w_carry  = (r_shift_a[0] & r_shift_b[0]) |
                      (r_shift_a[0] & r_carry)      |
                      (r_shift_b[0] & r_carry);
    assign w_accept = i_start && (r_state != RUN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_shift_a <= '0;
            r_shift_b <= '0;
            r_shift_s <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= '0;
            r_c_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_shift_a <= i_a;
                        r_shift_b <= i_b;
                        r_carry   <= i_c_in;
                        r_cnt     <= '0;
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                RUN: begin
                    r_shift_a <= {1'b0, r_shift_a[WIDTH-1:1]};
                    r_shift_b <= {1'b0, r_shift_b[WIDTH-1:1]};
                    r_shift_s <= {w_s, r_shift_s[WIDTH-1:1]};
                    r_carry   <= w_carry;
                    r_cnt     <= r_cnt + 1'b1;
                    // sum/c_out only move on the final bit, so the previous result stays visible during RUN.
                    if (r_cnt == LAST_BIT) begin
                        r_sum   <= {w_s, r_shift_s[WIDTH-1:1]};
                        r_c_out <= w_carry;
                        r_cnt   <= '0;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_sum   = r_sum;
    assign o_c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: handshake timing and results against
// a plain-arithmetic model of a + b + c_in.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cIn = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cOut;

    int testsRun = 0;
    int testsFailed = 0;

    serial_adder #(.WIDTH(W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_a    (a),
        .i_b    (b),
        .i_c_in (cIn),
        .o_busy (busy),
        .o_done (done),
        .o_sum  (sum),
        .o_c_out(cOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: unsigned addition of the full operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] eSum, output logic eCo);
        int total;
        total = int'(ma) + int'(mb) + int'(mc);
        eSum = W'(total % (1 << W));
        eCo  = (total >= (1 << W));
    endtask

    // Issue one operation from idle and observe the handshake for a bounded window.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         output logic [W-1:0] s, output logic co,
                         output int lat, output int busyCnt, output int doneCnt);
        a = oa; b = ob; cIn = oc; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cIn = 1'($urandom);
        lat = -1; busyCnt = 0; doneCnt = 0; s = 'x; co = 1'bx;
        for (int i = 0; i < W + 4; i++) begin
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) begin
                doneCnt++;
                if (lat < 0) begin
                    lat = i; s = sum; co = cOut;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        testsRun++;
        if (sum !== '0) begin testsFailed++; $display("[TB] FAIL reset_sum got=%0d want=0", sum); end
        testsRun++;
        if (cOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_cout got=%b want=0", cOut); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        testsRun++;
        if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    endtask

    task automatic test_basic();
        logic [W-1:0] s; logic co; int lat, bc, dc;
        do_op(4'd8, 4'd3, 1'b0, s, co, lat, bc, dc);
        testsRun++;
        if (lat !== W) begin testsFailed++; $display("[TB] FAIL basic_latency got=%0d want=%0d", lat, W); end
        testsRun++;
        if (bc !== W) begin testsFailed++; $display("[TB] FAIL basic_busy_cycles got=%0d want=%0d", bc, W); end
        testsRun++;
        if (dc !== 1) begin testsFailed++; $display("[TB] FAIL basic_done_pulses got=%0d want=1", dc); end
        testsRun++;
        if (s !== 4'd11) begin testsFailed++; $display("[TB] FAIL basic_sum got=%0d want=11", s); end
        testsRun++;
        if (co !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_cout got=%b want=0", co); end
        testsRun++;
        if (sum !== 4'd11) begin testsFailed++; $display("[TB] FAIL basic_sum_hold got=%0d want=11", sum); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] s; logic co; int lat, bc, dc;
        do_op(4'd15, 4'd1, 1'b0, s, co, lat, bc, dc);
        testsRun++;
        if (s !== 4'd0 || co !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ovf_15_1 got=%b_%0d want=1_0", co, s);
        end
        do_op(4'd15, 4'd15, 1'b1, s, co, lat, bc, dc);
        testsRun++;
        if (s !== 4'd15 || co !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ovf_15_15_1 got=%b_%0d want=1_15", co, s);
        end
    endtask

    task automatic test_roundtrip();
        int pa [6] = '{14, 11, 5, 3, 2, 7};
        int pb [6] = '{0, 3, 5, 1, 1, 1};
        logic [W-1:0] s; logic co; int lat, bc, dc;
        for (int k = 0; k < 6; k++) begin
            do_op(W'(pa[k] - pb[k]), W'(pb[k]), 1'b0, s, co, lat, bc, dc);
            testsRun++;
            if (s !== W'(pa[k]) || co !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL roundtrip_%0d_%0d got=%b_%0d want=0_%0d", pa[k], pb[k], co, s, pa[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] s, ra, rb, eSum; logic co, rc, eCo; int lat, bc, dc;
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            model(ra, rb, rc, eSum, eCo);
            do_op(ra, rb, rc, s, co, lat, bc, dc);
            testsRun++;
            if (s !== eSum || co !== eCo || lat !== W || dc !== 1) begin
                testsFailed++;
                $display("[TB] FAIL random_%0d+%0d+%0d got=%b_%0d lat=%0d dones=%0d want=%b_%0d lat=%0d dones=1",
                         ra, rb, rc, co, s, lat, dc, eCo, eSum, W);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int bc = 0, dc = 0;
        logic [W-1:0] s = 'x;
        a = 4'd1; b = 4'd2; cIn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin dc++; s = sum; end
            start = (i == 1);
            if (i == 1) begin a = 4'd9; b = 4'd9; end
            tick();
        end
        start = 1'b0;
        testsRun++;
        if (dc !== 1) begin testsFailed++; $display("[TB] FAIL busy_start_dones got=%0d want=1", dc); end
        testsRun++;
        if (s !== 4'd3) begin testsFailed++; $display("[TB] FAIL busy_start_sum got=%0d want=3", s); end
        testsRun++;
        if (bc !== W) begin testsFailed++; $display("[TB] FAIL busy_start_cycles got=%0d want=%0d", bc, W); end
    endtask

    task automatic test_back_to_back();
        int doneAt [$];
        logic [W-1:0] doneSum [$];
        int bc = 0;
        logic busyGap = 1'bx, busyResume = 1'bx;
        logic [W-1:0] midSum = 'x;
        a = 4'd6; b = 4'd7; cIn = 1'b0; start = 1'b1;
        tick();
        a = 4'd2; b = 4'd2;
        for (int i = 0; i < 13; i++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin doneAt.push_back(i); doneSum.push_back(sum); end
            if (i == W) busyGap = busy;
            if (i == W + 1) busyResume = busy;
            if (i == W + 3) midSum = sum;
            if (i == W + 1) start = 1'b0;
            tick();
        end
        testsRun++;
        if (doneAt.size() !== 2) begin
            testsFailed++; $display("[TB] FAIL b2b_done_count got=%0d want=2", doneAt.size());
        end else begin
            testsRun++;
            if (doneAt[0] !== W || doneSum[0] !== 4'd13) begin
                testsFailed++; $display("[TB] FAIL b2b_first got=@%0d sum=%0d want=@%0d sum=13", doneAt[0], doneSum[0], W);
            end
            testsRun++;
            if (doneAt[1] !== 2 * W + 1 || doneSum[1] !== 4'd4) begin
                testsFailed++; $display("[TB] FAIL b2b_second got=@%0d sum=%0d want=@%0d sum=4", doneAt[1], doneSum[1], 2 * W + 1);
            end
        end
        testsRun++;
        if (busyGap !== 1'b0 || busyResume !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL b2b_gap got=%b%b want=01", busyGap, busyResume);
        end
        testsRun++;
        if (midSum !== 4'd13) begin testsFailed++; $display("[TB] FAIL b2b_sum_hold got=%0d want=13", midSum); end
        testsRun++;
        if (bc !== 2 * W) begin testsFailed++; $display("[TB] FAIL b2b_busy_cycles got=%0d want=%0d", bc, 2 * W); end
    endtask

    task automatic test_reset_mid();
        int dc = 0, bc = 0;
        logic [W-1:0] s; logic co; int lat, bc2, dc2;
        a = 4'd9; b = 4'd4; cIn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        testsRun++;
        if (busy !== 1'b0 || sum !== '0 || cOut !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL midrst_state got=busy%b sum%0d cout%b want=busy0 sum0 cout0", busy, sum, cOut);
        end
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) dc++;
            if (busy === 1'b1) bc++;
            tick();
        end
        testsRun++;
        if (dc !== 0 || bc !== 0) begin
            testsFailed++; $display("[TB] FAIL midrst_quiet got=dones%0d busy%0d want=dones0 busy0", dc, bc);
        end
        do_op(4'd9, 4'd4, 1'b0, s, co, lat, bc2, dc2);
        testsRun++;
        if (s !== 4'd13 || co !== 1'b0 || lat !== W) begin
            testsFailed++; $display("[TB] FAIL midrst_fresh got=%b_%0d lat=%0d want=0_13 lat=%0d", co, s, lat, W);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_roundtrip();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
